// File: rtl/io_intr_unit.sv
// io_intr_unit: I/O flags (FGI/FGO), interrupt enable, INPR/OUTR device
// registers with ready/valid handshakes, and the interrupt request FSM.
// IN/OUT instructions that cannot complete are held via a combinational stall.
module io_intr_unit #(
    parameter int DATA_W = 16,
    parameter int IO_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [4:0]        opcode,
    input  logic              rFI,
    input  logic              rFO,
    input  logic              sFO,
    input  logic              ION,
    input  logic              IOF,
    input  logic [DATA_W-1:0] out_wdata,
    output logic [DATA_W-1:0] in_rdata,
    output logic              io_stall,
    input  logic              in_valid,
    input  logic [IO_W-1:0]   in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [IO_W-1:0]   out_data,
    input  logic              out_ready,
    output logic              irq,
    input  logic              irq_ack,
    output logic              fgi,
    output logic              fgo,
    output logic              ien
);

    localparam logic [4:0] OP_IN  = 5'b11000;
    localparam logic [4:0] OP_OUT = 5'b11001;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic            fgi_reg, fgi_next;
    logic            fgo_reg, fgo_next;
    logic            ien_reg, ien_next;
    logic            out_pend_reg, out_pend_next;
    logic            irq_reg, irq_next;
    logic [IO_W-1:0] inpr_reg, inpr_next;
    logic [IO_W-1:0] outr_reg, outr_next;
    logic [1:0]      state_reg, state_next;

    logic is_in, is_out;
    logic instr_ok;
    logic exec_in, exec_out;
    logic in_accept, out_accept;

    // Instruction decode, stall and handshake qualification.
    assign is_in      = (opcode == OP_IN);
    assign is_out     = (opcode == OP_OUT);
    assign io_stall   = instr_valid & ((is_in & ~fgi_reg) | (is_out & out_pend_reg));
    // A stalled instruction, including its strobes, has no effect.
    assign instr_ok   = instr_valid & ~io_stall;
    assign exec_in    = instr_ok & is_in;
    assign exec_out   = instr_ok & is_out;
    assign in_accept  = in_valid & ~fgi_reg;
    assign out_accept = out_pend_reg & out_ready;

    // Flag, data register and enable next-state logic.
    always_comb begin
        fgi_next      = fgi_reg;
        fgo_next      = fgo_reg;
        ien_next      = ien_reg;
        out_pend_next = out_pend_reg;
        inpr_next     = inpr_reg;
        outr_next     = outr_reg;

        // Device write and IN cannot coincide (in_ready is low when FGI=1),
        // so the set simply takes priority over the rFI/IN clear.
        if (in_accept) begin
            fgi_next  = 1'b1;
            inpr_next = in_data;
        end else if (exec_in || (instr_ok && rFI)) begin
            fgi_next = 1'b0;
        end

        // Set sources for FGO beat clear sources in the same cycle.
        if (out_accept || (instr_ok && sFO)) begin
            fgo_next = 1'b1;
        end else if (exec_out || (instr_ok && rFO)) begin
            fgo_next = 1'b0;
        end

        // OUT only executes with nothing pending, so load and drain are exclusive.
        if (exec_out) begin
            out_pend_next = 1'b1;
            outr_next     = out_wdata[IO_W-1:0];
        end else if (out_accept) begin
            out_pend_next = 1'b0;
        end

        // Disabling (IOF or taking the interrupt) wins over ION.
        if ((instr_ok && IOF) || irq_ack) begin
            ien_next = 1'b0;
        end else if (instr_ok && ION) begin
            ien_next = 1'b1;
        end
    end

    // Interrupt FSM next-state; irq is the registered decode of REQ.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ien_reg && (fgi_reg || fgo_reg)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_next = ST_SERVICE;
                end else if (!ien_next) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (instr_ok && ION) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        irq_next = (state_next == ST_REQ);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fgi_reg      <= 1'b0;
            fgo_reg      <= 1'b0;
            ien_reg      <= 1'b1;
            out_pend_reg <= 1'b0;
            irq_reg      <= 1'b0;
            inpr_reg     <= '0;
            outr_reg     <= '0;
            state_reg    <= ST_IDLE;
        end else begin
            fgi_reg      <= fgi_next;
            fgo_reg      <= fgo_next;
            ien_reg      <= ien_next;
            out_pend_reg <= out_pend_next;
            irq_reg      <= irq_next;
            inpr_reg     <= inpr_next;
            outr_reg     <= outr_next;
            state_reg    <= state_next;
        end
    end

    // INPR is zero-extended onto the CPU data width.
    generate
        if (DATA_W > IO_W) begin : g_rdata_ext
            logic unused_wdata_hi;
            assign in_rdata        = {{(DATA_W-IO_W){1'b0}}, inpr_reg};
            assign unused_wdata_hi = ^out_wdata[DATA_W-1:IO_W];
        end else begin : g_rdata_eq
            assign in_rdata = inpr_reg;
        end
    endgenerate

    assign in_ready  = ~fgi_reg;
    assign out_valid = out_pend_reg;
    assign out_data  = outr_reg;
    assign irq       = irq_reg;
    assign fgi       = fgi_reg;
    assign fgo       = fgo_reg;
    assign ien       = ien_reg;

endmodule

// File: tb/tb_io_intr_unit.sv
// Testbench for io_intr_unit: directed vector table, async reset check,
// then randomized cycles against a behavioural reference model.
module tb_io_intr_unit;

    localparam logic [4:0] NOP = 5'b00000;
    localparam logic [4:0] IN  = 5'b11000;
    localparam logic [4:0] OUT = 5'b11001;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [4:0]  opcode;
    logic        rFI, rFO, sFO, ION, IOF;
    logic [15:0] out_wdata;
    logic [15:0] in_rdata;
    logic        io_stall;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        irq;
    logic        irq_ack;
    logic        fgi, fgo, ien;

    int checks = 0;
    int errors = 0;

    io_intr_unit #(.DATA_W(16), .IO_W(8)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .rFI(rFI), .rFO(rFO), .sFO(sFO), .ION(ION), .IOF(IOF),
        .out_wdata(out_wdata), .in_rdata(in_rdata), .io_stall(io_stall),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .irq(irq), .irq_ack(irq_ack), .fgi(fgi), .fgo(fgo), .ien(ien)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic        iv;
        logic [4:0]  op;
        logic        rfi, rfo, sfo, ion, iof;
        logic [15:0] wdata;
        logic        inv;
        logic [7:0]  ind;
        logic        ordy, ack;
        logic        e_stall;
        logic        e_fgi, e_fgo, e_ien, e_irq, e_outv;
        logic [7:0]  e_outd;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t tbl [23];

    task automatic drive_idle();
        instr_valid = 0; opcode = NOP; rFI = 0; rFO = 0; sFO = 0; ION = 0; IOF = 0;
        out_wdata = 0; in_valid = 0; in_data = 0; out_ready = 0; irq_ack = 0;
    endtask

    // Behavioural model: flags, enable, pending byte and the interrupt phase
    // kept as two booleans (request outstanding / handler running).
    bit       m_fgi, m_fgo, m_ien, m_pend, m_irq, m_svc;
    bit [7:0] m_inpr, m_outr;

    task automatic model_reset();
        m_fgi = 0; m_fgo = 0; m_ien = 1; m_pend = 0; m_irq = 0; m_svc = 0;
        m_inpr = 0; m_outr = 0;
    endtask

    function automatic bit model_stall();
        return instr_valid && ((opcode == IN && !m_fgi) || (opcode == OUT && m_pend));
    endfunction

    task automatic model_step();
        bit ok, n_fgi, n_fgo, n_ien, n_pend, n_irq, n_svc;
        bit [7:0] n_inpr, n_outr;
        ok = instr_valid && !model_stall();
        n_fgi = m_fgi; n_fgo = m_fgo; n_ien = m_ien; n_pend = m_pend;
        n_irq = m_irq; n_svc = m_svc; n_inpr = m_inpr; n_outr = m_outr;
        if (in_valid && !m_fgi) begin
            n_fgi = 1; n_inpr = in_data;
        end else if (ok && (opcode == IN || rFI)) begin
            n_fgi = 0;
        end
        if ((m_pend && out_ready) || (ok && sFO)) n_fgo = 1;
        else if (ok && (opcode == OUT || rFO)) n_fgo = 0;
        if (ok && opcode == OUT) begin
            n_pend = 1; n_outr = out_wdata[7:0];
        end else if (m_pend && out_ready) begin
            n_pend = 0;
        end
        if ((ok && IOF) || irq_ack) n_ien = 0;
        else if (ok && ION) n_ien = 1;
        if (m_irq) begin
            if (irq_ack) begin n_irq = 0; n_svc = 1; end
            else if (!n_ien) n_irq = 0;
        end else if (m_svc) begin
            if (ok && ION) n_svc = 0;
        end else begin
            n_irq = m_ien && (m_fgi || m_fgo);
        end
        m_fgi = n_fgi; m_fgo = n_fgo; m_ien = n_ien; m_pend = n_pend;
        m_irq = n_irq; m_svc = n_svc; m_inpr = n_inpr; m_outr = n_outr;
    endtask

    initial begin
        drive_idle();
        reset = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1;
        #1;
        chk("rst_fgi", {15'd0, fgi}, 16'd0);
        chk("rst_fgo", {15'd0, fgo}, 16'd0);
        chk("rst_ien", {15'd0, ien}, 16'd1);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_outv", {15'd0, out_valid}, 16'd0);
        chk("rst_inrdy", {15'd0, in_ready}, 16'd1);

        //          iv op  rfi rfo sfo ion iof wdata     inv ind    ordy ack stl fgi fgo ien irq outv outd   rdata
        tbl[0]  = '{0, NOP, 0, 0, 0, 0, 0, 16'h0000, 1, 8'hA5, 0, 0,   0,  1,  0,  1,  0,  0, 8'h00, 16'h00A5};
        tbl[1]  = '{0, NOP, 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  1,  0,  1,  1,  0, 8'h00, 16'h00A5};
        tbl[2]  = '{0, NOP, 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 1,   0,  1,  0,  0,  0,  0, 8'h00, 16'h00A5};
        tbl[3]  = '{0, NOP, 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  1,  0,  0,  0,  0, 8'h00, 16'h00A5};
        tbl[4]  = '{1, IN,  0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  0,  0,  0,  0,  0, 8'h00, 16'h00A5};
        tbl[5]  = '{1, IN,  0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   1,  0,  0,  0,  0,  0, 8'h00, 16'h00A5};
        tbl[6]  = '{0, NOP, 0, 0, 0, 0, 0, 16'h0000, 1, 8'h3C, 0, 0,   0,  1,  0,  0,  0,  0, 8'h00, 16'h003C};
        tbl[7]  = '{1, NOP, 0, 0, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  1,  0,  1,  0,  0, 8'h00, 16'h003C};
        tbl[8]  = '{0, NOP, 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  1,  0,  1,  1,  0, 8'h00, 16'h003C};
        tbl[9]  = '{1, NOP, 0, 0, 0, 0, 1, 16'h0000, 0, 8'h00, 0, 1,   0,  1,  0,  0,  0,  0, 8'h00, 16'h003C};
        tbl[10] = '{1, IN,  0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  0,  0,  0,  0,  0, 8'h00, 16'h003C};
        tbl[11] = '{1, OUT, 0, 0, 0, 0, 0, 16'h12F0, 0, 8'h00, 0, 0,   0,  0,  0,  0,  0,  1, 8'hF0, 16'h003C};
        tbl[12] = '{1, OUT, 0, 0, 0, 0, 0, 16'h5555, 0, 8'h00, 0, 0,   1,  0,  0,  0,  0,  1, 8'hF0, 16'h003C};
        tbl[13] = '{1, OUT, 0, 0, 0, 0, 0, 16'h5555, 0, 8'h00, 0, 0,   1,  0,  0,  0,  0,  1, 8'hF0, 16'h003C};
        tbl[14] = '{1, OUT, 0, 0, 0, 0, 0, 16'h5555, 0, 8'h00, 0, 0,   1,  0,  0,  0,  0,  1, 8'hF0, 16'h003C};
        tbl[15] = '{1, OUT, 0, 0, 0, 0, 0, 16'h5555, 0, 8'h00, 1, 0,   1,  0,  1,  0,  0,  0, 8'hF0, 16'h003C};
        tbl[16] = '{1, OUT, 0, 0, 0, 0, 0, 16'h5555, 0, 8'h00, 0, 0,   0,  0,  0,  0,  0,  1, 8'h55, 16'h003C};
        tbl[17] = '{1, NOP, 0, 1, 1, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  0,  1,  0,  0,  1, 8'h55, 16'h003C};
        tbl[18] = '{1, NOP, 0, 0, 0, 1, 1, 16'h0000, 0, 8'h00, 0, 0,   0,  0,  1,  0,  0,  1, 8'h55, 16'h003C};
        tbl[19] = '{1, NOP, 0, 0, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  0,  1,  1,  0,  1, 8'h55, 16'h003C};
        tbl[20] = '{0, NOP, 0, 0, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 0,   0,  0,  1,  1,  1,  1, 8'h55, 16'h003C};
        tbl[21] = '{1, NOP, 1, 0, 0, 0, 0, 16'h0000, 1, 8'h77, 0, 0,   0,  1,  1,  1,  1,  1, 8'h55, 16'h0077};
        tbl[22] = '{1, OUT, 0, 0, 0, 0, 0, 16'h00AB, 0, 8'h00, 0, 0,   1,  1,  1,  1,  1,  1, 8'h55, 16'h0077};

        @(posedge clk); #1;
        for (int i = 0; i < 23; i++) begin
            instr_valid = tbl[i].iv; opcode = tbl[i].op;
            rFI = tbl[i].rfi; rFO = tbl[i].rfo; sFO = tbl[i].sfo; ION = tbl[i].ion; IOF = tbl[i].iof;
            out_wdata = tbl[i].wdata; in_valid = tbl[i].inv; in_data = tbl[i].ind;
            out_ready = tbl[i].ordy; irq_ack = tbl[i].ack;
            #1;
            chk($sformatf("v%0d_stall", i), {15'd0, io_stall}, {15'd0, tbl[i].e_stall});
            @(posedge clk); #1;
            chk($sformatf("v%0d_fgi", i), {15'd0, fgi}, {15'd0, tbl[i].e_fgi});
            chk($sformatf("v%0d_inrdy", i), {15'd0, in_ready}, {15'd0, ~tbl[i].e_fgi});
            chk($sformatf("v%0d_fgo", i), {15'd0, fgo}, {15'd0, tbl[i].e_fgo});
            chk($sformatf("v%0d_ien", i), {15'd0, ien}, {15'd0, tbl[i].e_ien});
            chk($sformatf("v%0d_irq", i), {15'd0, irq}, {15'd0, tbl[i].e_irq});
            chk($sformatf("v%0d_outv", i), {15'd0, out_valid}, {15'd0, tbl[i].e_outv});
            chk($sformatf("v%0d_outd", i), {8'd0, out_data}, {8'd0, tbl[i].e_outd});
            chk($sformatf("v%0d_rdata", i), in_rdata, tbl[i].e_rdata);
            $display("vec %0d: iv=%b op=%b stall=%b fgi=%b fgo=%b ien=%b irq=%b outv=%b outd=%h rdata=%h",
                     i, tbl[i].iv, tbl[i].op, io_stall, fgi, fgo, ien, irq, out_valid, out_data, in_rdata);
        end

        // Asynchronous reset mid-transfer: out_pend=1 and irq=1 at this point.
        drive_idle();
        #1 reset = 0;
        #1;
        chk("arst_outv", {15'd0, out_valid}, 16'd0);
        chk("arst_irq", {15'd0, irq}, 16'd0);
        chk("arst_fgi", {15'd0, fgi}, 16'd0);
        chk("arst_fgo", {15'd0, fgo}, 16'd0);
        chk("arst_ien", {15'd0, ien}, 16'd1);
        chk("arst_outd", {8'd0, out_data}, 16'd0);
        chk("arst_rdata", in_rdata, 16'd0);
        $display("async reset: outv=%b irq=%b fgi=%b fgo=%b ien=%b", out_valid, irq, fgi, fgo, ien);
        @(negedge clk) reset = 1;

        // Randomized cycles against the reference model.
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            int sel;
            @(posedge clk); #1;
            instr_valid = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 3);
            case (sel)
                0: opcode = IN;
                1: opcode = OUT;
                2: opcode = NOP;
                default: opcode = 5'($urandom_range(0, 31));
            endcase
            rFI = ($urandom_range(0, 5) == 0);
            rFO = ($urandom_range(0, 5) == 0);
            sFO = ($urandom_range(0, 5) == 0);
            ION = ($urandom_range(0, 4) == 0);
            IOF = ($urandom_range(0, 5) == 0);
            out_wdata = 16'($urandom);
            in_valid = ($urandom_range(0, 2) == 0);
            in_data = 8'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            irq_ack = ($urandom_range(0, 7) == 0);
            #1;
            chk("rnd_stall", {15'd0, io_stall}, {15'd0, model_stall()});
            chk("rnd_fgi", {15'd0, fgi}, {15'd0, m_fgi});
            chk("rnd_inrdy", {15'd0, in_ready}, {15'd0, !m_fgi});
            chk("rnd_fgo", {15'd0, fgo}, {15'd0, m_fgo});
            chk("rnd_ien", {15'd0, ien}, {15'd0, m_ien});
            chk("rnd_irq", {15'd0, irq}, {15'd0, m_irq});
            chk("rnd_outv", {15'd0, out_valid}, {15'd0, m_pend});
            chk("rnd_outd", {8'd0, out_data}, {8'd0, m_outr});
            chk("rnd_rdata", in_rdata, {8'd0, m_inpr});
            $display("rnd %0d: iv=%b op=%b stall=%b fgi=%b fgo=%b ien=%b irq=%b outv=%b",
                     c, instr_valid, opcode, io_stall, fgi, fgo, ien, irq, out_valid);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
